// File: rtl/face_bbox_extract.sv
// face_bbox_extract
//   Per-frame foreground bounding box and pixel count over a PARALLEL_NUM-pixel-parallel binary
//   video stream. Each frame produces one result record, strobed on o_bbox_valid. Video passes
//   through with one register stage of delay.
//
//   Optional feature macro: BBOX_OVERLAY_EN. When it is defined, pixels on the border of the last
//   published box (o_found=1) are replaced by 8'h80 on o_binary. When it is undefined, o_binary
//   is a pure delayed copy of i_binary.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_binary             PARALLEL_NUM pixels; pixel k = i_binary[k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   i_valid              beat valid
//   i_user               start of frame (first beat only; qualified by i_valid)
//   i_last               end of line (qualified by i_valid)
//   o_binary/o_valid/o_user/o_last   inputs delayed by one clock
//   o_bbox_valid         one-cycle strobe: result fields updated
//   o_found              pixel count >= MIN_PIXELS
//   o_x_min/o_x_max      box columns (0 when not found)
//   o_y_min/o_y_max      box rows (0 when not found)
//   o_pix_count          foreground pixel count, saturating
//   o_frame_err          malformed frame (line length or line count)
module face_bbox_extract #(
  parameter int unsigned PARALLEL_NUM = 4,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH    = 1280,
  parameter int unsigned IMG_HEIGHT   = 720,
  parameter int unsigned MIN_PIXELS   = 64,
  localparam int unsigned XW = $clog2(IMG_WIDTH),
  localparam int unsigned YW = $clog2(IMG_HEIGHT),
  localparam int unsigned CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1),
  localparam int unsigned DW = PARALLEL_NUM * PIXEL_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_binary,
  input  logic          i_valid,
  input  logic          i_user,
  input  logic          i_last,
  output logic [DW-1:0] o_binary,
  output logic          o_valid,
  output logic          o_user,
  output logic          o_last,
  output logic          o_bbox_valid,
  output logic          o_found,
  output logic [XW-1:0] o_x_min,
  output logic [XW-1:0] o_x_max,
  output logic [YW-1:0] o_y_min,
  output logic [YW-1:0] o_y_max,
  output logic [CW-1:0] o_pix_count,
  output logic          o_frame_err
);

  localparam int unsigned BEATS = IMG_WIDTH / PARALLEL_NUM;
  // Beat index can reach BEATS, which marks an over-long line.
  localparam int unsigned BW    = $clog2(BEATS + 1);
  localparam int unsigned KW    = (PARALLEL_NUM > 1) ? $clog2(PARALLEL_NUM) : 1;
  localparam int unsigned PCW   = $clog2(PARALLEL_NUM + 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e state_q, state_d;

  logic sof;
  logic start, beat, early, finish;
  logic last_line;
  logic found;

  logic [BW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [XW-1:0]  x_min_q, x_min_d, x_max_q, x_max_d;
  logic [YW-1:0]  y_min_q, y_min_d, y_max_q, y_max_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW:0]    cnt_sum;
  logic           err_q, err_d;
  logic [XW-1:0]  col_lo, col_hi;

  logic [PARALLEL_NUM-1:0] fg;
  logic [KW-1:0]           k_lo, k_hi;
  logic [PCW-1:0]          pop;
  logic [DW-1:0]           bin_out;

  assign sof   = i_valid & i_user;
  assign found = (cnt_q >= CW'(MIN_PIXELS));

  // Foreground flags, lowest/highest set lane and popcount of the current beat.
  always_comb begin
    fg = '0;
    for (int k = 0; k < int'(PARALLEL_NUM); k++) fg[k] = i_binary[k*PIXEL_WIDTH];
  end

  always_comb begin
    k_lo = '0;
    k_hi = '0;
    pop  = '0;
    for (int k = int'(PARALLEL_NUM) - 1; k >= 0; k--) begin
      if (fg[k]) k_lo = KW'(k);
    end
    for (int k = 0; k < int'(PARALLEL_NUM); k++) begin
      if (fg[k]) k_hi = KW'(k);
      pop = pop + PCW'(fg[k]);
    end
  end

  // FSM: state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (sof) state_d = last_line ? StDone : StActive;
      StActive: if (i_valid && last_line) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: control outputs. An SOF while active both publishes the partial frame and restarts.
  always_comb begin
    start  = 1'b0;
    beat   = 1'b0;
    early  = 1'b0;
    finish = 1'b0;
    unique case (state_q)
      StIdle:   start = sof;
      StActive: begin
        start = sof;
        early = sof;
        beat  = i_valid & ~sof;
      end
      StDone:   finish = 1'b1;
      default:  ;
    endcase
  end

  // Accumulator next state; a starting beat accumulates on top of the empty-frame values.
  always_comb begin
    x_d       = start ? '0 : x_q;
    y_d       = start ? '0 : y_q;
    x_min_d   = start ? '1 : x_min_q;
    x_max_d   = start ? '0 : x_max_q;
    y_min_d   = start ? '1 : y_min_q;
    y_max_d   = start ? '0 : y_max_q;
    cnt_d     = start ? '0 : cnt_q;
    err_d     = start ? 1'b0 : err_q;
    col_lo    = XW'(32'(x_d) * PARALLEL_NUM + 32'(k_lo));
    col_hi    = XW'(32'(x_d) * PARALLEL_NUM + 32'(k_hi));
    cnt_sum   = {1'b0, cnt_d} + (CW+1)'(pop);
    last_line = 1'b0;
    if (x_d < BW'(BEATS)) begin
      if (|fg) begin
        if (col_lo < x_min_d) x_min_d = col_lo;
        if (col_hi > x_max_d) x_max_d = col_hi;
        if (y_d < y_min_d)    y_min_d = y_d;
        if (y_d > y_max_d)    y_max_d = y_d;
      end
      cnt_d = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    end else begin
      err_d = 1'b1;
    end
    if (i_last) begin
      if (x_d != BW'(BEATS - 1)) err_d = 1'b1;
      last_line = (y_d == YW'(IMG_HEIGHT - 1));
      x_d       = '0;
      y_d       = y_d + YW'(1);
    end else if (x_d < BW'(BEATS)) begin
      x_d = x_d + BW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (start || beat) begin
      x_q     <= x_d;
      y_q     <= y_d;
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Result record. Published from the accumulators as they stood before this cycle's beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bbox_valid <= 1'b0;
      o_found      <= 1'b0;
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_pix_count  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      o_bbox_valid <= finish | early;
      if (finish || early) begin
        o_found     <= found;
        o_x_min     <= found ? x_min_q : '0;
        o_x_max     <= found ? x_max_q : '0;
        o_y_min     <= found ? y_min_q : '0;
        o_y_max     <= found ? y_max_q : '0;
        o_pix_count <= cnt_q;
        o_frame_err <= early | err_q;
      end else if (start) begin
        o_frame_err <= 1'b0;
      end
    end
  end

`ifdef BBOX_OVERLAY_EN
  // Input-side position of the beat now being registered into o_binary.
  logic [BW-1:0] ov_x_q, ov_x;
  logic [YW-1:0] ov_y_q, ov_y;
  logic [31:0]   ov_col;
  logic          ov_in_x, ov_in_y;

  always_comb begin
    ov_x    = sof ? '0 : ov_x_q;
    ov_y    = sof ? '0 : ov_y_q;
    bin_out = i_binary;
    ov_col  = '0;
    ov_in_x = 1'b0;
    ov_in_y = (ov_y >= o_y_min) && (ov_y <= o_y_max);
    if (i_valid && o_found) begin
      for (int k = 0; k < int'(PARALLEL_NUM); k++) begin
        ov_col  = 32'(ov_x) * PARALLEL_NUM + 32'(k);
        ov_in_x = (ov_col >= 32'(o_x_min)) && (ov_col <= 32'(o_x_max));
        if ((ov_in_x && (ov_y == o_y_min || ov_y == o_y_max)) ||
            (ov_in_y && (ov_col == 32'(o_x_min) || ov_col == 32'(o_x_max)))) begin
          bin_out[k*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(8'h80);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_x_q <= '0;
      ov_y_q <= '0;
    end else if (i_valid) begin
      if (i_last) begin
        ov_x_q <= '0;
        ov_y_q <= ov_y + YW'(1);
      end else begin
        ov_x_q <= (ov_x < BW'(BEATS)) ? ov_x + BW'(1) : ov_x;
        ov_y_q <= ov_y;
      end
    end
  end
`else
  assign bin_out = i_binary;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_binary <= '0;
      o_valid  <= 1'b0;
      o_user   <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      o_binary <= bin_out;
      o_valid  <= i_valid;
      o_user   <= i_user;
      o_last   <= i_last;
    end
  end

endmodule

// File: tb/tb_face_bbox_extract.sv
// Bench for face_bbox_extract on a reduced 32x16 frame. Two instances share the stimulus:
// dut uses MIN_PIXELS=3, dut1 uses MIN_PIXELS=1.
module tb_face_bbox_extract;

  localparam int P     = 4;
  localparam int W     = 32;
  localparam int H     = 16;
  localparam int BEATS = W / P;
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);
  localparam int CW    = $clog2(W * H + 1);
  localparam int RW    = 2 + 2 * XW + 2 * YW + CW;
  localparam int MIN0  = 3;
  localparam int MIN1  = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] i_binary = '0;
  logic i_valid = 1'b0, i_user = 1'b0, i_last = 1'b0;

  logic [31:0] ob0, ob1;
  logic ov0, ou0, ol0, bv0, found0, err0;
  logic ov1, ou1, ol1, bv1, found1, err1;
  logic [XW-1:0] xmin0, xmax0, xmin1, xmax1;
  logic [YW-1:0] ymin0, ymax0, ymin1, ymax1;
  logic [CW-1:0] cnt0, cnt1;
  logic [RW-1:0] rec0, rec1, e0, e1;

  assign rec0 = {found0, xmin0, xmax0, ymin0, ymax0, cnt0, err0};
  assign rec1 = {found1, xmin1, xmax1, ymin1, ymax1, cnt1, err1};

  int n_vec = 0, n_mis = 0, n_strobe = 0;
  bit img [H][W];
  logic [31:0] obuf [H][BEATS];

  always #5 clk = ~clk;
  always @(negedge clk) if (bv0 === 1'b1) n_strobe++;

  face_bbox_extract #(.PARALLEL_NUM(P), .PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                      .MIN_PIXELS(MIN0)) dut (
    .i_clk(clk), .i_rst(rst), .i_binary(i_binary), .i_valid(i_valid), .i_user(i_user),
    .i_last(i_last), .o_binary(ob0), .o_valid(ov0), .o_user(ou0), .o_last(ol0),
    .o_bbox_valid(bv0), .o_found(found0), .o_x_min(xmin0), .o_x_max(xmax0), .o_y_min(ymin0),
    .o_y_max(ymax0), .o_pix_count(cnt0), .o_frame_err(err0));

  face_bbox_extract #(.PARALLEL_NUM(P), .PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                      .MIN_PIXELS(MIN1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_binary(i_binary), .i_valid(i_valid), .i_user(i_user),
    .i_last(i_last), .o_binary(ob1), .o_valid(ov1), .o_user(ou1), .o_last(ol1),
    .o_bbox_valid(bv1), .o_found(found1), .o_x_min(xmin1), .o_x_max(xmax1), .o_y_min(ymin1),
    .o_y_max(ymax1), .o_pix_count(cnt1), .o_frame_err(err1));

  // Reference: scan the pixels actually delivered and derive the record directly.
  function automatic logic [RW-1:0] model(input int lines, input int sl, input int sb,
                                          input int minp, input bit err);
    int xmn, xmx, ymn, ymx, cnt, lim;
    xmn = W; xmx = -1; ymn = H; ymx = -1; cnt = 0;
    for (int y = 0; y < lines; y++) begin
      lim = W;
      if (y == sl) lim = ((sb < BEATS) ? sb : BEATS) * P;
      for (int x = 0; x < lim; x++) begin
        if (img[y][x]) begin
          cnt++;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
      end
    end
    if (cnt >= minp)
      return {1'b1, XW'(xmn), XW'(xmx), YW'(ymn), YW'(ymx), CW'(cnt), err};
    return {1'b0, XW'(0), XW'(0), YW'(0), YW'(0), CW'(cnt), err};
  endfunction

  function automatic logic [31:0] beat_data(input int y, input int b);
    logic [31:0] d;
    d = 32'hFFFF_FFFF;
    if (b < BEATS)
      for (int k = 0; k < P; k++) d[k*8 +: 8] = img[y][b*P+k] ? 8'hFF : 8'h00;
    return d;
  endfunction

  task automatic put(input logic [31:0] d, input logic u, input logic l);
    i_binary = d; i_valid = 1'b1; i_user = u; i_last = l;
    @(posedge clk); #1;
    i_valid = 1'b0; i_user = 1'b0; i_last = 1'b0;
  endtask

  task automatic idle();
    i_binary = $urandom; i_valid = 1'b0; i_user = 1'($urandom); i_last = 1'($urandom);
    @(posedge clk); #1;
    i_user = 1'b0; i_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_user = 1'b0; i_last = 1'b0; i_binary = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_img();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic rand_img(input int pct);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(99) < pct);
  endtask

  // Streams lines 0..lines-1; line sl carries sb beats (beats past the width are all-ones).
  task automatic send_frame(input int lines, input int sl, input int sb, input bit skip_sof,
                            input int idle_pct);
    int nb;
    for (int y = 0; y < lines; y++) begin
      nb = (y == sl) ? sb : BEATS;
      for (int b = 0; b < nb; b++) begin
        if (!(skip_sof && y == 0 && b == 0)) begin
          for (int n = 0; n < 6; n++) if ($urandom_range(99) < idle_pct) idle();
          put(beat_data(y, b), (y == 0 && b == 0), (b == nb - 1));
          if (b < BEATS) obuf[y][b] = ob0;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({ob0, ov0, ou0, ol0, bv0, rec0} !== '0) begin
      n_mis++; $display("FAIL reset_outputs: got %h want 0", {ob0, ov0, ou0, ol0, bv0, rec0});
    end
    n_vec++;
    if ({ob1, ov1, ou1, ol1, bv1, rec1} !== '0) begin
      n_mis++; $display("FAIL reset_outputs1: got %h want 0", {ob1, ov1, ou1, ol1, bv1, rec1});
    end
  endtask

  task automatic test_empty();
    clear_img();
    send_frame(H, -1, 0, 0, 0);
    n_vec++;
    if (bv0 !== 1'b0) begin n_mis++; $display("FAIL empty_early_strobe: got %b want 0", bv0); end
    @(posedge clk); #1;
    n_vec++;
    if (bv0 !== 1'b1) begin n_mis++; $display("FAIL empty_strobe: got %b want 1", bv0); end
    e0 = model(H, -1, 0, MIN0, 1'b0);
    n_vec++;
    if (rec0 !== e0) begin n_mis++; $display("FAIL empty_rec: got %h want %h", rec0, e0); end
    @(posedge clk); #1;
    n_vec++;
    if (bv0 !== 1'b0) begin n_mis++; $display("FAIL empty_strobe_width: got %b want 0", bv0); end
  endtask

  task automatic test_single_pixel();
    clear_img();
    img[3][5] = 1'b1;
    send_frame(H, -1, 0, 0, 0);
    @(posedge clk); #1;
    e1 = {1'b1, XW'(5), XW'(5), YW'(3), YW'(3), CW'(1), 1'b0};
    e0 = {1'b0, XW'(0), XW'(0), YW'(0), YW'(0), CW'(1), 1'b0};
    n_vec++;
    if (bv1 !== 1'b1 || rec1 !== e1) begin
      n_mis++; $display("FAIL single_min1: got %b/%h want 1/%h", bv1, rec1, e1);
    end
    n_vec++;
    if (rec0 !== e0) begin n_mis++; $display("FAIL single_min3: got %h want %h", rec0, e0); end
    // Exactly MIN0 pixels at the frame corners: threshold and edge coordinates.
    clear_img();
    img[0][0] = 1'b1; img[15][31] = 1'b1; img[9][7] = 1'b1;
    send_frame(H, -1, 0, 0, 0);
    @(posedge clk); #1;
    e0 = {1'b1, XW'(0), XW'(31), YW'(0), YW'(15), CW'(3), 1'b0};
    n_vec++;
    if (bv0 !== 1'b1 || rec0 !== e0) begin
      n_mis++; $display("FAIL corners_min3: got %b/%h want 1/%h", bv0, rec0, e0);
    end
  endtask

  task automatic test_rect();
    clear_img();
    for (int y = 4; y <= 11; y++) for (int x = 3; x <= 20; x++) img[y][x] = 1'b1;
    send_frame(H, -1, 0, 0, 0);
    @(posedge clk); #1;
    e0 = {1'b1, XW'(3), XW'(20), YW'(4), YW'(11), CW'(144), 1'b0};
    n_vec++;
    if (bv0 !== 1'b1 || rec0 !== e0) begin
      n_mis++; $display("FAIL rect: got %b/%h want 1/%h", bv0, rec0, e0);
    end
    n_vec++;
    if (rec1 !== e0) begin n_mis++; $display("FAIL rect1: got %h want %h", rec1, e0); end
  endtask

`ifdef BBOX_OVERLAY_EN
  task automatic test_overlay();
    rand_img(50);
    send_frame(H, -1, 0, 0, 0);
    n_vec++;
    if (obuf[4][0][31:24] !== 8'h80) begin
      n_mis++; $display("FAIL overlay_tl: got %h want 80", obuf[4][0][31:24]);
    end
    n_vec++;
    if (obuf[11][5][7:0] !== 8'h80) begin
      n_mis++; $display("FAIL overlay_br: got %h want 80", obuf[11][5][7:0]);
    end
    n_vec++;
    if (obuf[5][1][7:0] !== (img[5][4] ? 8'hFF : 8'h00)) begin
      n_mis++; $display("FAIL overlay_inner: got %h want %h", obuf[5][1][7:0],
                        img[5][4] ? 8'hFF : 8'h00);
    end
    n_vec++;
    if (obuf[4][0][23:16] !== (img[4][2] ? 8'hFF : 8'h00)) begin
      n_mis++; $display("FAIL overlay_outside: got %h want %h", obuf[4][0][23:16],
                        img[4][2] ? 8'hFF : 8'h00);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      rand_img($urandom_range(1, 60));
      send_frame(H, -1, 0, 0, 50);
      n_vec++;
      if (bv0 !== 1'b0) begin n_mis++; $display("FAIL rand_early_strobe: got %b want 0", bv0); end
      @(posedge clk); #1;
      e0 = model(H, -1, 0, MIN0, 1'b0);
      e1 = model(H, -1, 0, MIN1, 1'b0);
      n_vec++;
      if (bv0 !== 1'b1 || rec0 !== e0) begin
        n_mis++; $display("FAIL rand_frame%0d: got %b/%h want 1/%h", f, bv0, rec0, e0);
      end
      n_vec++;
      if (rec1 !== e1) begin n_mis++; $display("FAIL rand_frame%0d_1: got %h want %h", f, rec1, e1); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_sof();
    rand_img(40);
    send_frame(12, 10, 7, 0, 25);
    n_vec++;
    if (bv0 !== 1'b0) begin n_mis++; $display("FAIL early_no_strobe: got %b want 0", bv0); end
    e0 = model(12, 10, 7, MIN0, 1'b1);
    e1 = model(12, 10, 7, MIN1, 1'b1);
    put(beat_data(0, 0), 1'b1, 1'b0);
    n_vec++;
    if (bv0 !== 1'b1 || rec0 !== e0) begin
      n_mis++; $display("FAIL early_partial: got %b/%h want 1/%h", bv0, rec0, e0);
    end
    n_vec++;
    if (rec1 !== e1) begin n_mis++; $display("FAIL early_partial1: got %h want %h", rec1, e1); end
    send_frame(H, -1, 0, 1, 25);
    @(posedge clk); #1;
    e0 = model(H, -1, 0, MIN0, 1'b0);
    n_vec++;
    if (bv0 !== 1'b1 || rec0 !== e0) begin
      n_mis++; $display("FAIL early_clean_next: got %b/%h want 1/%h", bv0, rec0, e0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    rand_img(30);
    send_frame(H, 5, BEATS + 1, 0, 0);
    @(posedge clk); #1;
    e0 = model(H, 5, BEATS + 1, MIN0, 1'b1);
    n_vec++;
    if (bv0 !== 1'b1 || rec0 !== e0) begin
      n_mis++; $display("FAIL overrun: got %b/%h want 1/%h", bv0, rec0, e0);
    end
    @(posedge clk); #1;
    put(beat_data(0, 0), 1'b1, 1'b0);
    n_vec++;
    if (err0 !== 1'b0) begin n_mis++; $display("FAIL err_clear_at_sof: got %b want 0", err0); end
    send_frame(H, -1, 0, 1, 0);
    @(posedge clk); #1;
    e0 = model(H, -1, 0, MIN0, 1'b0);
    n_vec++;
    if (rec0 !== e0) begin n_mis++; $display("FAIL overrun_next: got %h want %h", rec0, e0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic v, u, l;
    int beats, s0;
    do_reset();
    s0 = n_strobe;
    beats = 0;
    for (int c = 0; c < 60; c++) begin
      v = (c == 0) ? 1'b1 : 1'($urandom_range(1));
      d = $urandom;
      u = v ? (c == 0) : 1'($urandom);
      l = v ? (beats % BEATS == BEATS - 1) : 1'($urandom);
      i_binary = d; i_valid = v; i_user = u; i_last = l;
      @(posedge clk); #1;
      n_vec++;
      if ({ob0, ov0, ou0, ol0} !== {d, v, u, l}) begin
        n_mis++; $display("FAIL passthrough: got %h want %h", {ob0, ov0, ou0, ol0}, {d, v, u, l});
      end
      if (v) beats++;
    end
    do_reset();
    n_vec++;
    if ({ob0, ov0, ou0, ol0, bv0, rec0} !== '0) begin
      n_mis++; $display("FAIL midframe_reset: got %h want 0", {ob0, ov0, ou0, ol0, bv0, rec0});
    end
    for (int c = 0; c < 4; c++) idle();
    n_vec++;
    if (n_strobe !== s0) begin
      n_mis++; $display("FAIL aborted_strobe: got %0d want %0d", n_strobe, s0);
    end
    rand_img(35);
    send_frame(H, -1, 0, 0, 50);
    @(posedge clk); #1;
    e0 = model(H, -1, 0, MIN0, 1'b0);
    n_vec++;
    if (bv0 !== 1'b1 || rec0 !== e0) begin
      n_mis++; $display("FAIL after_abort: got %b/%h want 1/%h", bv0, rec0, e0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single_pixel();
    test_rect();
`ifdef BBOX_OVERLAY_EN
    test_overlay();
`endif
    test_random_frames();
    test_early_sof();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
